// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared constants and types for the I2C bus front end.
//   I2C_SYNC_STAGES  : default depth of each pad synchroniser chain
//   I2C_FILTER_LEN   : default number of agreeing cycles before a filtered level flips
//   I2C_IDLE_TIMEOUT : default cycles without a filtered edge before a busy bus is released
//   i2c_bus_state_t  : bus ownership state seen by the busy tracker
package i2c_pkg;

  localparam int I2C_SYNC_STAGES  = 2;
  localparam int I2C_FILTER_LEN   = 3;
  localparam int I2C_IDLE_TIMEOUT = 1024;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } i2c_bus_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Conditions one open-drain pad line: synchroniser chain followed by a
//   glitch filter. Also reports, combinationally, that the filtered level is
//   about to flip on the coming clock edge so the parent can register all of
//   its strobes in the same cycle the filtered level changes.
// Ports
//   i_clk       : system clock
//   i_rst       : asynchronous active-high reset (line reads as idle-high)
//   i_raw       : pad input, asynchronous to i_clk
//   o_filt      : synchronised, deglitched level
//   o_rise_nxt  : o_filt goes 0->1 on the next clock edge
//   o_fall_nxt  : o_filt goes 1->0 on the next clock edge
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_filt,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [CW-1:0]          r_cnt;
  logic                   w_s;
  logic                   w_flip;

  // Synchroniser resets to 1 so a released reset looks like an idle bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  // Flip on the FILTER_LEN-th consecutive disagreeing sample.
  assign w_flip = (w_s != r_filt) && (r_cnt == CNT_LAST);

  // Any agreeing sample restarts the count, so short pulses die out here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (w_s == r_filt) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_filt <= w_s;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_filt     = r_filt;
  assign o_rise_nxt = w_flip & w_s;
  assign o_fall_nxt = w_flip & ~w_s;

endmodule

// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend
//   Front end between the SCL/SDA pads and the I2C slave. Produces clean
//   filtered levels, SCL edge strobes, START/STOP strobes, a bus-busy flag
//   and a stuck-bus timeout strobe. All strobes are registered together here
//   so they line up with the cycle in which the filtered levels change.
// Ports
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   i_scl_raw, i_sda_raw     : asynchronous pad inputs
//   o_scl_filt, o_sda_filt   : filtered levels
//   o_scl_rise, o_scl_fall   : 1-cycle SCL edge strobes
//   o_start_det, o_stop_det  : 1-cycle START (incl. repeated) / STOP strobes
//   o_bus_busy               : high between START and STOP or timeout
//   o_timeout                : 1-cycle strobe when the idle timer frees the bus
module i2c_bus_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES  = I2C_SYNC_STAGES,
  parameter int FILTER_LEN   = I2C_FILTER_LEN,
  parameter int IDLE_TIMEOUT = I2C_IDLE_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl_raw,
  input  logic i_sda_raw,
  output logic o_scl_filt,
  output logic o_sda_filt,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_bus_busy,
  output logic o_timeout
);

  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(IDLE_TIMEOUT - 1);

  i2c_bus_state_t r_state;
  i2c_bus_state_t w_state_nxt;
  logic [TW-1:0]  r_idle_cnt;
  logic           r_scl_rise;
  logic           r_scl_fall;
  logic           r_start_det;
  logic           r_stop_det;
  logic           r_timeout;

  logic w_scl_rise_nxt;
  logic w_scl_fall_nxt;
  logic w_sda_rise_nxt;
  logic w_sda_fall_nxt;
  logic w_scl_flip;
  logic w_edge;
  logic w_start;
  logic w_stop;
  logic w_tmr_hit;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_raw      (i_scl_raw),
    .o_filt     (o_scl_filt),
    .o_rise_nxt (w_scl_rise_nxt),
    .o_fall_nxt (w_scl_fall_nxt)
  );

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_raw      (i_sda_raw),
    .o_filt     (o_sda_filt),
    .o_rise_nxt (w_sda_rise_nxt),
    .o_fall_nxt (w_sda_fall_nxt)
  );

  // START/STOP need SCL high now and not flipping at the same edge; a
  // simultaneous flip of both lines is ambiguous and yields neither.
  // A filtered edge on the same edge the timer expires keeps the bus busy.
  always_comb begin
    w_scl_flip = w_scl_rise_nxt | w_scl_fall_nxt;
    w_edge     = w_scl_flip | w_sda_rise_nxt | w_sda_fall_nxt;
    w_start    = w_sda_fall_nxt & o_scl_filt & ~w_scl_flip;
    w_stop     = w_sda_rise_nxt & o_scl_filt & ~w_scl_flip;
    w_tmr_hit  = (r_state == BUS_BUSY) && !w_edge && (r_idle_cnt == TMR_LAST);
  end

  // Busy tracker: repeated START keeps BUSY, STOP in IDLE is harmless.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUS_IDLE: if (w_start) w_state_nxt = BUS_BUSY;
      BUS_BUSY: begin
        if (w_start) begin
          w_state_nxt = BUS_BUSY;
        end else if (w_stop || w_tmr_hit) begin
          w_state_nxt = BUS_IDLE;
        end
      end
      default: w_state_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BUS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle timer only runs while busy and restarts on every filtered edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else if ((r_state == BUS_IDLE) || w_edge || w_tmr_hit) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_rise  <= 1'b0;
      r_scl_fall  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_scl_rise  <= w_scl_rise_nxt;
      r_scl_fall  <= w_scl_fall_nxt;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
      r_timeout   <= w_tmr_hit;
    end
  end

  assign o_scl_rise  = r_scl_rise;
  assign o_scl_fall  = r_scl_fall;
  assign o_start_det = r_start_det;
  assign o_stop_det  = r_stop_det;
  assign o_timeout   = r_timeout;
  assign o_bus_busy  = (r_state == BUS_BUSY);

endmodule
